// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM encoding
// and the baud divider helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an idle-high serial line; reset forces the idle
// level so the receiver never sees a false start bit coming out of reset.
module uart_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous line.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with LED latch for the last good frame.
// Optional error counter output enabled by defining UART_RX_ERRCNT_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LED_W     = 4
) (
    input  logic                 sysclk,
    input  logic                 rstn,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [LED_W-1:0]     led
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CPB - 1);

    // Odd parity expects data^parity == 1, even expects 0.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic expect_one;
        expect_one = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;
        return ((^d) ^ p) != expect_one;
    endfunction

    uart_state_e            state_r;
    uart_state_e            next_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   perr_r;
    logic                   ferr_r;
    logic                   armed_r;
    logic                   rx_s;
    logic                   tick_s;
    logic                   half_s;
    logic                   last_data_s;
    logic                   last_stop_s;
    logic                   valid_s;
    logic                   perr_s;
    logic                   ferr_s;

    // Note: rstn is an active-high synchronous reset despite its name.
    uart_bit_sync u_sync (
        .clk  (sysclk),
        .rst  (rstn),
        .din  (uart_rx),
        .dout (rx_s)
    );

    assign tick_s      = (cnt_r == FULL_C);
    assign half_s      = (cnt_r == HALF_C);
    assign last_data_s = (bit_cnt_r == BIT_W'(DATA_BITS - 1));
    assign last_stop_s = (bit_cnt_r == BIT_W'(STOP_BITS - 1));

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; armed_r blocks re-triggering on a held-low break.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s && armed_r) next_state_s = ST_START;
                else                  next_state_s = ST_IDLE;
            end
            ST_START: begin
                if (half_s) next_state_s = rx_s ? ST_IDLE : ST_DATA;
                else        next_state_s = ST_START;
            end
            ST_DATA: begin
                if (tick_s && last_data_s)
                    next_state_s = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                else
                    next_state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (tick_s) next_state_s = ST_STOP;
                else        next_state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (tick_s && last_stop_s) next_state_s = ST_DONE;
                else                       next_state_s = ST_STOP;
            end
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Baud/bit counters, shift register and per-frame error flags.
    always_ff @(posedge sysclk) begin
        if (rstn) begin
            cnt_r     <= CNT_W'(0);
            bit_cnt_r <= BIT_W'(0);
            shift_r   <= DATA_BITS'(0);
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            if (next_state_s != state_r || state_r == ST_IDLE || tick_s)
                cnt_r <= CNT_W'(0);
            else
                cnt_r <= cnt_r + CNT_W'(1);

            if (next_state_s != state_r)
                bit_cnt_r <= BIT_W'(0);
            else if (tick_s && (state_r == ST_DATA || state_r == ST_STOP))
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);

            if (state_r == ST_DATA && tick_s)
                shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};

            if (state_r == ST_IDLE)
                perr_r <= 1'b0;
            else if (state_r == ST_PARITY && tick_s)
                perr_r <= parity_bad(shift_r, rx_s);

            if (state_r == ST_IDLE)
                ferr_r <= 1'b0;
            else if (state_r == ST_STOP && tick_s && !rx_s)
                ferr_r <= 1'b1;

            if (state_r == ST_DONE && ferr_r)
                armed_r <= 1'b0;
            else if (rx_s)
                armed_r <= 1'b1;
        end
    end

    // FSM output decode: frame error outranks parity error.
    always_comb begin
        valid_s = 1'b0;
        perr_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            ST_DONE: begin
                if (ferr_r)      ferr_s  = 1'b1;
                else if (perr_r) perr_s  = 1'b1;
                else             valid_s = 1'b1;
            end
            default: begin
                valid_s = 1'b0;
                perr_s  = 1'b0;
                ferr_s  = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge sysclk) begin
        if (rstn) begin
            rx_data    <= DATA_BITS'(0);
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            led        <= LED_W'(0);
        end else begin
            rx_valid   <= valid_s;
            parity_err <= perr_s;
            frame_err  <= ferr_s;
            busy       <= (next_state_s != ST_IDLE);
            if (valid_s) begin
                rx_data <= shift_r;
                led     <= shift_r[LED_W-1:0];
            end
        end
    end

`ifdef UART_RX_ERRCNT_EN
    // Saturating count of error pulses.
    always_ff @(posedge sysclk) begin
        if (rstn) begin
            err_cnt <= 16'h0000;
        end else if ((ferr_s || perr_s) && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end
`endif

endmodule
